fault_campaign_sequencer: RTL and testbench

Synthesizable fault-injection campaign controller for gate-netlist fault-sensitivity runs. It drives a fault-instrumented combinational DUT with a multi-rate pseudo-random stimulus and compacts the DUT response into a MISR signature. It first runs one fault-free golden pass, then one pass per fault ID in a programmable range, and reports a detected/undetected result per fault over a valid/ready stream. It sits between the campaign host (range, step count, result sink) and the netlist's built-in fault MUXes, which are keyed by `fault_id`/`fault_en`.

---
 rtl/fault_campaign_pkg.sv | 35 +++
 rtl/galois_shift_reg.sv | 41 ++++
 rtl/fault_campaign_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fault_campaign_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fault_campaign_pkg.sv
// Shared types and default constants for the fault campaign sequencer.
package fault_campaign_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_G,
    ST_FLUSH_G,
    ST_RUN_F,
    ST_FLUSH_F,
    ST_REPORT,
    ST_FIN
  } state_t;

  localparam int DEF_FID_W  = 10;
  localparam int DEF_RESP_W = 30;

  // One reported fault outcome at the default widths.
  typedef struct packed {
    logic [DEF_FID_W-1:0]  fid;
    logic                  detected;
    logic [DEF_RESP_W-1:0] signature;
  } result_t;

  // x^60 + x^59 + 1 in Galois form (x^60 implied by the shift-out bit).
  localparam logic [59:0] LFSR_POLY_60 = 60'h800000000000001;
  localparam logic [59:0] LFSR_SEED_60 = 60'hC39E12A84D7B055;
  // x^30 + x^6 + x^4 + x + 1 in Galois form.
  localparam logic [29:0] MISR_POLY_30 = 30'h00000053;

  // True when a power-of-two period divides the step index.
  function automatic logic period_hit(input logic [31:0] k, input int unsigned per);
    return (k & (per - 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/galois_shift_reg.sv
// Galois shift register with parallel XOR input; used as both LFSR and MISR.
module galois_shift_reg #(
  parameter int               WIDTH   = 30,
  parameter logic [WIDTH-1:0] POLY    = '0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] step_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // One Galois step with the parallel input folded in; load has priority.
  always_comb begin
    step_o = {sr_q[WIDTH-2:0], 1'b0} ^ (sr_q[WIDTH-1] ? POLY : '0) ^ din;
    sr_d   = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = step_o;
    end
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign state_o = sr_q;

endmodule

// File: rtl/fault_campaign_sequencer.sv
// Golden pass followed by one pass per fault ID; compares each MISR signature
// against the golden one and streams the outcome out over valid/ready.
module fault_campaign_sequencer
  import fault_campaign_pkg::*;
#(
  parameter int                STIM_W    = 60,
  parameter int                RESP_W    = 30,
  parameter int                FID_W     = 10,
  parameter int                STEP_W    = 16,
  parameter int                LO_BITS   = 18,
  parameter int                MID_BITS  = 22,
  parameter int                HI_PER    = 2,
  parameter int                MID_PER   = 8,
  parameter int                LO_PER    = 64,
  parameter logic [STIM_W-1:0] LFSR_POLY = LFSR_POLY_60,
  parameter logic [STIM_W-1:0] LFSR_SEED = LFSR_SEED_60,
  parameter logic [RESP_W-1:0] MISR_POLY = MISR_POLY_30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FID_W-1:0]  fid_start,
  input  logic [FID_W-1:0]  fid_end,
  input  logic [STEP_W-1:0] num_steps,
  output logic [STIM_W-1:0] stim,
  input  logic [RESP_W-1:0] resp,
  output logic              fault_en,
  output logic [FID_W-1:0]  fault_id,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FID_W-1:0]  res_fid,
  output logic              res_detected,
  output logic [RESP_W-1:0] res_signature,
  output logic [FID_W:0]    detected_count
);

  state_t            state_q, state_d;
  logic [FID_W-1:0]  fid_start_q, fid_start_d, fid_end_q, fid_end_d;
  logic [STEP_W-1:0] n_q, n_d, k_q, k_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [FID_W-1:0]  fault_id_q, fault_id_d;
  logic [RESP_W-1:0] golden_q, golden_d;
  logic [FID_W-1:0]  res_fid_q, res_fid_d;
  logic              res_det_q, res_det_d;
  logic [RESP_W-1:0] res_sig_q, res_sig_d;
  logic [FID_W:0]    det_cnt_q, det_cnt_d;

  logic              pass_start, in_run, misr_abs, last_fault, has_faults;
  logic              hit_lo, hit_mid, hit_hi;
  logic [STIM_W-1:0] lfsr_q, lfsr_step_unused;
  logic [RESP_W-1:0] misr_q, misr_step;

  assign last_fault = (fault_id_q + FID_W'(1)) == fid_end_q;
  assign has_faults = fid_start_q < fid_end_q;
  assign hit_lo     = period_hit(32'(k_q), LO_PER);
  assign hit_mid    = period_hit(32'(k_q), MID_PER);
  assign hit_hi     = period_hit(32'(k_q), HI_PER);

  galois_shift_reg #(.WIDTH(STIM_W), .POLY(LFSR_POLY), .RST_VAL(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (pass_start),
    .load_val(LFSR_SEED),
    .shift   (in_run),
    .din     ('0),
    .state_o (lfsr_q),
    .step_o  (lfsr_step_unused)
  );

  galois_shift_reg #(.WIDTH(RESP_W), .POLY(MISR_POLY), .RST_VAL('0)) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (pass_start),
    .load_val('0),
    .shift   (misr_abs),
    .din     (resp),
    .state_o (misr_q),
    .step_o  (misr_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-step pass jumps straight to its FLUSH state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = (num_steps == '0) ? ST_FLUSH_G : ST_RUN_G;
      ST_RUN_G:   if (k_q == n_q - STEP_W'(1)) state_d = ST_FLUSH_G;
      ST_FLUSH_G: begin
        if (!has_faults)      state_d = ST_FIN;
        else if (n_q == '0)   state_d = ST_FLUSH_F;
        else                  state_d = ST_RUN_F;
      end
      ST_RUN_F:   if (k_q == n_q - STEP_W'(1)) state_d = ST_FLUSH_F;
      ST_FLUSH_F: state_d = ST_REPORT;
      ST_REPORT: begin
        if (res_ready) begin
          if (last_fault)     state_d = ST_FIN;
          else if (n_q == '0) state_d = ST_FLUSH_F;
          else                state_d = ST_RUN_F;
        end
      end
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Status outputs and datapath strobes decoded from the state.
  always_comb begin
    busy       = state_q != ST_IDLE;
    done       = state_q == ST_FIN;
    res_valid  = state_q == ST_REPORT;
    fault_en   = (state_q == ST_RUN_F) || (state_q == ST_FLUSH_F) || (state_q == ST_REPORT);
    in_run     = (state_q == ST_RUN_G) || (state_q == ST_RUN_F);
    // The first RUN cycle has no preceding stim update, so it absorbs nothing.
    misr_abs   = (in_run && (k_q != '0)) ||
                 (((state_q == ST_FLUSH_G) || (state_q == ST_FLUSH_F)) && (n_q != '0));
    pass_start = ((state_q == ST_IDLE) && start) ||
                 ((state_q == ST_FLUSH_G) && has_faults) ||
                 ((state_q == ST_REPORT) && res_ready && !last_fault);
  end

  // Campaign datapath: stimulus lanes, step counter, golden and result capture.
  always_comb begin
    fid_start_d = fid_start_q;
    fid_end_d   = fid_end_q;
    n_d         = n_q;
    k_d         = k_q;
    stim_d      = stim_q;
    fault_id_d  = fault_id_q;
    golden_d    = golden_q;
    res_fid_d   = res_fid_q;
    res_det_d   = res_det_q;
    res_sig_d   = res_sig_q;
    det_cnt_d   = det_cnt_q;

    if ((state_q == ST_IDLE) && start) begin
      fid_start_d = fid_start;
      fid_end_d   = fid_end;
      n_d         = num_steps;
      det_cnt_d   = '0;
    end

    if (pass_start) begin
      k_d = '0;
    end else if (in_run) begin
      k_d = k_q + STEP_W'(1);
    end

    if (in_run) begin
      for (int b = 0; b < STIM_W; b++) begin
        if (b < LO_BITS) begin
          if (hit_lo) stim_d[b] = lfsr_q[b];
        end else if (b < LO_BITS + MID_BITS) begin
          if (hit_mid) stim_d[b] = lfsr_q[b];
        end else begin
          if (hit_hi) stim_d[b] = lfsr_q[b];
        end
      end
    end

    // The final absorption and its capture share the same edge.
    if (state_q == ST_FLUSH_G) begin
      golden_d = misr_step;
      if (has_faults) fault_id_d = fid_start_q;
    end

    if (state_q == ST_FLUSH_F) begin
      res_fid_d = fault_id_q;
      res_sig_d = misr_step;
      res_det_d = misr_step != golden_q;
    end

    if ((state_q == ST_REPORT) && res_ready) begin
      if (res_det_q && (det_cnt_q != '1)) det_cnt_d = det_cnt_q + 1'b1;
      if (!last_fault) fault_id_d = fault_id_q + FID_W'(1);
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fid_start_q <= '0;
      fid_end_q   <= '0;
      n_q         <= '0;
      k_q         <= '0;
      stim_q      <= '0;
      fault_id_q  <= '0;
      golden_q    <= '0;
      res_fid_q   <= '0;
      res_det_q   <= 1'b0;
      res_sig_q   <= '0;
      det_cnt_q   <= '0;
    end else begin
      fid_start_q <= fid_start_d;
      fid_end_q   <= fid_end_d;
      n_q         <= n_d;
      k_q         <= k_d;
      stim_q      <= stim_d;
      fault_id_q  <= fault_id_d;
      golden_q    <= golden_d;
      res_fid_q   <= res_fid_d;
      res_det_q   <= res_det_d;
      res_sig_q   <= res_sig_d;
      det_cnt_q   <= det_cnt_d;
    end
  end

  assign stim           = stim_q;
  assign fault_id       = fault_id_q;
  assign res_fid        = res_fid_q;
  assign res_detected   = res_det_q;
  assign res_signature  = res_sig_q;
  assign detected_count = det_cnt_q;

endmodule

// File: tb/tb_fault_campaign_sequencer.sv
// Directed bench for fault_campaign_sequencer with a stuck-at DUT model.
module tb_fault_campaign_sequencer;
  import fault_campaign_pkg::*;

  localparam logic [59:0] SEED = LFSR_SEED_60;
  localparam logic [59:0] LP   = LFSR_POLY_60;
  localparam logic [29:0] MP   = MISR_POLY_30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  fid_start = '0, fid_end = '0;
  logic [15:0] num_steps = '0;
  logic [59:0] stim;
  logic [29:0] resp;
  logic        fault_en, busy, done, res_valid, res_detected;
  logic        res_ready = 1'b1;
  logic [9:0]  fault_id, res_fid;
  logic [29:0] res_signature;
  logic [10:0] detected_count;

  fault_campaign_sequencer #(
    .STIM_W(60), .RESP_W(30), .FID_W(10), .STEP_W(16), .LO_BITS(18), .MID_BITS(22),
    .HI_PER(2), .MID_PER(8), .LO_PER(64), .LFSR_POLY(LP), .LFSR_SEED(SEED), .MISR_POLY(MP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fid_start(fid_start), .fid_end(fid_end),
    .num_steps(num_steps), .stim(stim), .resp(resp), .fault_en(fault_en), .fault_id(fault_id),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready), .res_fid(res_fid),
    .res_detected(res_detected), .res_signature(res_signature), .detected_count(detected_count)
  );

  always #5 clk = ~clk;

  // Fault-instrumented netlist stand-in: odd fault IDs pin one response bit low.
  always_comb begin
    resp = stim[29:0] ^ stim[59:30];
    if (fault_en && fault_id[0]) resp[5'(int'(fault_id) % 30)] = 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference stimulus sequence: mstim[k] is stim after step k's lane loads.
  logic [59:0] mstim [0:63];

  task automatic build_model(input int n);
    logic [59:0] l, s;
    int per;
    l = SEED;
    s = '0;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 60; b++) begin
        per = (b < 18) ? 64 : ((b < 40) ? 8 : 2);
        if (k % per == 0) s[b] = l[b];
      end
      mstim[k] = s;
      l = {l[58:0], 1'b0} ^ (l[59] ? LP : 60'd0);
    end
  endtask

  function automatic logic [29:0] model_sig(input int n, input logic fen, input int fid);
    logic [29:0] sig, r;
    sig = '0;
    for (int k = 0; k < n; k++) begin
      r = mstim[k][29:0] ^ mstim[k][59:30];
      if (fen && (fid % 2 == 1)) r[5'(fid % 30)] = 1'b0;
      sig = {sig[28:0], 1'b0} ^ (sig[29] ? MP : 30'd0) ^ r;
    end
    return sig;
  endfunction

  typedef struct {
    int         fs, fe, n, stall, nres, cnt, cyc;
    logic [7:0] mask;
  } vec_t;

  vec_t        vecs [4];
  result_t     cap_q [$];
  logic [29:0] first_sigs [8];

  // Runs one campaign; stall >= 0 holds res_ready low for 10 cycles on that result.
  task automatic run_campaign(input int fs, input int fe, input int n, input int stall,
                              output int cycles);
    int  cyc;
    logic stalled;
    result_t r;
    build_model(n);
    cap_q.delete();
    cycles  = -1;
    stalled = 1'b0;
    @(posedge clk); #1;
    fid_start = 10'(fs); fid_end = 10'(fe); num_steps = 16'(n);
    res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(busy), 64'd1);
    while (cyc < 3000) begin
      if (n > 0 && cyc >= 2 && cyc <= n + 1)
        chk("stim_golden_step", 64'(stim), 64'(mstim[cyc-2]));
      if (done) begin
        cycles = cyc + 1;
        break;
      end
      if (res_valid && !stalled && stall >= 0 && cap_q.size() == stall) begin
        stalled   = 1'b1;
        res_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1;
          cyc++;
          chk("stall_valid", 64'(res_valid), 64'd1);
          chk("stall_fid", 64'(res_fid), 64'(fs + stall));
          chk("stall_sig", 64'(res_signature), 64'(model_sig(n, 1'b1, fs + stall)));
          chk("stall_fault_id", 64'(fault_id), 64'(fs + stall));
          chk("stall_fault_en", 64'(fault_en), 64'd1);
          if (n > 0) chk("stall_stim", 64'(stim), 64'(mstim[n-1]));
        end
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        r.fid = res_fid; r.detected = res_detected; r.signature = res_signature;
        cap_q.push_back(r);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cycles < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_3000");
    end else begin
      @(posedge clk); #1;
      chk("done_pulse_width", 64'(done), 64'd0);
      chk("busy_fall", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, lim;
    vecs[0] = '{fs:0, fe:4, n:0,  stall:-1, nres:4, cnt:0, cyc:11,  mask:8'h00};
    vecs[1] = '{fs:0, fe:8, n:64, stall:-1, nres:8, cnt:4, cyc:595, mask:8'hAA};
    vecs[2] = '{fs:5, fe:5, n:16, stall:-1, nres:0, cnt:0, cyc:19,  mask:8'h00};
    vecs[3] = '{fs:2, fe:5, n:16, stall:1,  nres:3, cnt:1, cyc:83,  mask:8'h02};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_stim", 64'(stim), 64'd0);
    chk("rst_fault_en", 64'(fault_en), 64'd0);
    chk("rst_fault_id", 64'(fault_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sig", 64'(res_signature), 64'd0);
    chk("rst_det_count", 64'(detected_count), 64'd0);

    for (int v = 0; v < 4; v++) begin
      run_campaign(vecs[v].fs, vecs[v].fe, vecs[v].n, vecs[v].stall, cycles);
      chk("num_results", 64'(cap_q.size()), 64'(vecs[v].nres));
      chk("start_to_done_cycles", 64'(cycles), 64'(vecs[v].cyc));
      chk("detected_count", 64'(detected_count), 64'(vecs[v].cnt));
      lim = (cap_q.size() < vecs[v].nres) ? cap_q.size() : vecs[v].nres;
      for (int i = 0; i < lim; i++) begin
        chk("res_fid", 64'(cap_q[i].fid), 64'(vecs[v].fs + i));
        chk("res_detected", 64'(cap_q[i].detected), 64'(vecs[v].mask[i]));
        chk("res_signature", 64'(cap_q[i].signature), 64'(model_sig(vecs[v].n, 1'b1, vecs[v].fs + i)));
        if (vecs[v].n == 0) chk("zero_step_sig", 64'(cap_q[i].signature), 64'd0);
        if (!vecs[v].mask[i])
          chk("undetected_eq_golden", 64'(cap_q[i].signature), 64'(model_sig(vecs[v].n, 1'b0, 0)));
        if (v == 1) first_sigs[i] = cap_q[i].signature;
      end
    end

    // Reset in the middle of fid 3's fault pass.
    @(posedge clk); #1;
    fid_start = 10'd0; fid_end = 10'd8; num_steps = 16'd64; res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lim = 0;
    while (!(fault_en && fault_id == 10'd3 && !res_valid) && lim < 2000) begin
      @(posedge clk); #1;
      lim++;
    end
    chk("reach_fid3_run", 64'(lim < 2000), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fault_en", 64'(fault_en), 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_fault_id", 64'(fault_id), 64'd0);
    chk("midrst_stim", 64'(stim), 64'd0);
    rst = 1'b0;

    run_campaign(0, 8, 64, -1, cycles);
    chk("rerun_num_results", 64'(cap_q.size()), 64'd8);
    chk("rerun_cycles", 64'(cycles), 64'd595);
    chk("rerun_det_count", 64'(detected_count), 64'd4);
    lim = (cap_q.size() < 8) ? cap_q.size() : 8;
    for (int i = 0; i < lim; i++)
      chk("rerun_sig_bit_exact", 64'(cap_q[i].signature), 64'(first_sigs[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
